// File: rtl/dir_display_seq.sv
// Direction glyph display sequencer: OFF / STEADY / BLINK FSM with registered outputs.
// Define DIR_DISPLAY_BLINK_EN to enable blinking after a direction change.
module dir_display_seq #(
  parameter int NUM_DIGITS   = 4,
  parameter int BLINK_CYCLES = 25_000_000,
  parameter int BLINK_COUNT  = 3,
  parameter int CNT_W        = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [1:0]              direc,
  input  logic                    dir_valid,
  output logic [7*NUM_DIGITS-1:0] hex,
  output logic                    busy,
  output logic [CNT_W-1:0]        dir_changes
);

  if (NUM_DIGITS < 4 || NUM_DIGITS > 8 || BLINK_CYCLES < 1 || BLINK_COUNT < 1 || CNT_W < 1)
  begin : g_param_check
    $error("dir_display_seq: parameter out of range");
  end

  typedef enum logic [1:0] {S_OFF, S_STEADY, S_BLINK} state_t;

  state_t                  r_state, w_state_nx;
  logic [1:0]              r_cur_dir, w_dir_nx;
  logic [7*NUM_DIGITS-1:0] r_hex, w_hex_nx;
  logic [CNT_W-1:0]        r_cnt;
  logic                    w_change, w_inc, w_show;

`ifdef DIR_DISPLAY_BLINK_EN
  localparam int TMR_W  = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam int PAIR_W = (BLINK_COUNT  > 1) ? $clog2(BLINK_COUNT)  : 1;

  logic [TMR_W-1:0]  r_tmr, w_tmr_nx;
  logic [PAIR_W-1:0] r_pair, w_pair_nx;
  logic              r_phase, w_phase_nx;
  logic              r_busy;
`endif

  assign w_change = dir_valid && (direc != r_cur_dir);

  always_comb begin
    w_state_nx = r_state;
    w_dir_nx   = r_cur_dir;
    w_inc      = 1'b0;
`ifdef DIR_DISPLAY_BLINK_EN
    w_tmr_nx   = r_tmr;
    w_pair_nx  = r_pair;
    w_phase_nx = r_phase;
`endif
    if (!enable) begin
      w_state_nx = S_OFF;
    end else begin
      case (r_state)
        S_OFF: begin
          w_state_nx = S_STEADY;
          w_dir_nx   = direc;
        end
        S_STEADY: begin
          if (w_change) begin
            w_dir_nx = direc;
            w_inc    = 1'b1;
`ifdef DIR_DISPLAY_BLINK_EN
            w_state_nx = S_BLINK;
            w_tmr_nx   = '0;
            w_pair_nx  = '0;
            w_phase_nx = 1'b0;
`endif
          end
        end
`ifdef DIR_DISPLAY_BLINK_EN
        S_BLINK: begin
          if (w_change) begin
            w_dir_nx   = direc;
            w_inc      = 1'b1;
            w_tmr_nx   = '0;
            w_pair_nx  = '0;
            w_phase_nx = 1'b0;
          end else if (r_tmr == TMR_W'(BLINK_CYCLES - 1)) begin
            // End of a half-period: on->off, or off->next pair / back to STEADY
            w_tmr_nx = '0;
            if (!r_phase) begin
              w_phase_nx = 1'b1;
            end else begin
              w_phase_nx = 1'b0;
              if (r_pair == PAIR_W'(BLINK_COUNT - 1)) begin
                w_state_nx = S_STEADY;
                w_pair_nx  = '0;
              end else begin
                w_pair_nx = r_pair + 1'b1;
              end
            end
          end else begin
            w_tmr_nx = r_tmr + 1'b1;
          end
        end
`endif
        default: w_state_nx = S_OFF;
      endcase
    end
  end

  always_comb begin
    w_show = (w_state_nx == S_STEADY);
`ifdef DIR_DISPLAY_BLINK_EN
    if (w_state_nx == S_BLINK && !w_phase_nx) w_show = 1'b1;
`endif
    w_hex_nx = '1;
    if (w_show) begin
      case (w_dir_nx)
        2'b00: w_hex_nx[20:14] = 7'b0001110;
        2'b01: w_hex_nx[27:21] = 7'b0000011;
        2'b10: w_hex_nx[13:7]  = 7'b1000111;
        2'b11: w_hex_nx[6:0]   = 7'b0101111;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_OFF;
      r_cur_dir <= 2'b00;
      r_hex     <= '1;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_cur_dir <= w_dir_nx;
      r_hex     <= w_hex_nx;
      if (w_inc && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
    end
  end

`ifdef DIR_DISPLAY_BLINK_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tmr   <= '0;
      r_pair  <= '0;
      r_phase <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_tmr   <= w_tmr_nx;
      r_pair  <= w_pair_nx;
      r_phase <= w_phase_nx;
      r_busy  <= (w_state_nx == S_BLINK);
    end
  end

  assign busy = r_busy;
`else
  assign busy = 1'b0;
`endif

  assign hex         = r_hex;
  assign dir_changes = r_cnt;

endmodule

// File: tb/tb_dir_display_seq.sv
// Self-checking bench for dir_display_seq: directed vector table, directed
// corner sequences, and randomized stimulus against a behavioural model.
module tb_dir_display_seq;
  localparam int ND    = 5;
  localparam int BC    = 4;
  localparam int BN    = 2;
  localparam int CW    = 2;
  localparam int HW    = 7 * ND;
  localparam int TOTAL = 2 * BC * BN;
`ifdef DIR_DISPLAY_BLINK_EN
  localparam bit BLINK_EN = 1'b1;
`else
  localparam bit BLINK_EN = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          enable;
  logic [1:0]    direc;
  logic          dir_valid;
  logic [HW-1:0] hex;
  logic          busy;
  logic [CW-1:0] dir_changes;

  dir_display_seq #(
    .NUM_DIGITS  (ND),
    .BLINK_CYCLES(BC),
    .BLINK_COUNT (BN),
    .CNT_W       (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .direc      (direc),
    .dir_valid  (dir_valid),
    .hex        (hex),
    .busy       (busy),
    .dir_changes(dir_changes)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: enabled flag, current direction, blink cycles remaining, change count
  bit         m_on;
  logic [1:0] m_dir;
  int         m_left;
  int         m_cnt;

  localparam logic [HW-1:0] BLANK = '1;

  function automatic logic [HW-1:0] glyph(input logic [1:0] d);
    logic [HW-1:0] h;
    h = '1;
    case (d)
      2'b11: h[0*7 +: 7] = 7'b0101111;
      2'b10: h[1*7 +: 7] = 7'b1000111;
      2'b00: h[2*7 +: 7] = 7'b0001110;
      2'b01: h[3*7 +: 7] = 7'b0000011;
    endcase
    return h;
  endfunction

  function automatic logic [HW-1:0] m_hex();
    if (!m_on) return BLANK;
    if (m_left > 0 && (((TOTAL - m_left) / BC) % 2) == 1) return BLANK;
    return glyph(m_dir);
  endfunction

  task automatic model_edge();
    if (!rst_n) begin
      m_on = 0; m_dir = 2'b00; m_left = 0; m_cnt = 0;
    end else if (!enable) begin
      m_on = 0; m_left = 0;
    end else if (!m_on) begin
      m_on = 1; m_dir = direc;
    end else if (dir_valid && direc != m_dir) begin
      m_dir  = direc;
      m_cnt  = (m_cnt < (1 << CW) - 1) ? m_cnt + 1 : m_cnt;
      m_left = BLINK_EN ? TOTAL : 0;
    end else if (m_left > 0) begin
      m_left = m_left - 1;
    end
  endtask

  task automatic chk(input string name, input logic [HW-1:0] eh, input logic eb, input int ec);
    n_chk++;
    if (hex !== eh) begin
      n_err++;
      $display("FAIL %s hex: got %h expected %h", name, hex, eh);
    end
    n_chk++;
    if (busy !== eb) begin
      n_err++;
      $display("FAIL %s busy: got %b expected %b", name, busy, eb);
    end
    n_chk++;
    if (int'(dir_changes) != ec) begin
      n_err++;
      $display("FAIL %s dir_changes: got %0d expected %0d", name, dir_changes, ec);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic [1:0] d, input logic v);
    rst_n = r; enable = e; direc = d; dir_valid = v;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic mstep(input string name, input logic r, input logic e, input logic [1:0] d, input logic v);
    step(r, e, d, v);
    chk(name, m_hex(), m_left > 0, m_cnt);
  endtask

  typedef struct {
    logic          r;
    logic          e;
    logic [1:0]    d;
    logic          v;
    logic [HW-1:0] h;
    logic          b;
    int            c;
  } vec_t;

  vec_t tbl[8];
  int   busy_cycles;

  initial begin
    tbl[0] = '{1'b0, 1'b0, 2'b00, 1'b0, BLANK,        1'b0, 0};
    tbl[1] = '{1'b1, 1'b0, 2'b10, 1'b0, BLANK,        1'b0, 0};
    tbl[2] = '{1'b1, 1'b1, 2'b10, 1'b0, glyph(2'b10), 1'b0, 0};
    tbl[3] = '{1'b1, 1'b1, 2'b10, 1'b1, glyph(2'b10), 1'b0, 0};
    tbl[4] = '{1'b1, 1'b0, 2'b11, 1'b1, BLANK,        1'b0, 0};
    tbl[5] = '{1'b1, 1'b1, 2'b00, 1'b0, glyph(2'b00), 1'b0, 0};
    tbl[6] = '{1'b1, 1'b1, 2'b01, 1'b0, glyph(2'b00), 1'b0, 0};
    tbl[7] = '{1'b0, 1'b1, 2'b11, 1'b1, BLANK,        1'b0, 0};

    rst_n = 1'b0; enable = 1'b0; direc = 2'b00; dir_valid = 1'b0;
    m_on = 0; m_dir = 2'b00; m_left = 0; m_cnt = 0;

    for (int i = 0; i < 8; i++) begin
      step(tbl[i].r, tbl[i].e, tbl[i].d, tbl[i].v);
      chk($sformatf("vec%0d", i), tbl[i].h, tbl[i].b, tbl[i].c);
    end

    // Change forward -> right, then let the blink run out
    mstep("r031_rst", 1'b0, 1'b0, 2'b00, 1'b0);
    mstep("r031_en", 1'b1, 1'b1, 2'b00, 1'b0);
    busy_cycles = 0;
    mstep("r031_chg", 1'b1, 1'b1, 2'b11, 1'b1);
    if (busy) busy_cycles++;
    for (int i = 1; i < TOTAL + 4; i++) begin
      mstep($sformatf("r031_c%0d", i), 1'b1, 1'b1, 2'b11, 1'b0);
      if (busy) busy_cycles++;
    end
    n_chk++;
    if (busy_cycles != (BLINK_EN ? TOTAL : 0)) begin
      n_err++;
      $display("FAIL r031_busy_len: got %0d expected %0d", busy_cycles, BLINK_EN ? TOTAL : 0);
    end
    chk("r031_final", glyph(2'b11), 1'b0, 1);

    // Restart at cycle 6 of a blink, then enable drop and re-enable
    mstep("r032_rst", 1'b0, 1'b0, 2'b00, 1'b0);
    mstep("r032_en", 1'b1, 1'b1, 2'b00, 1'b0);
    mstep("r032_chg1", 1'b1, 1'b1, 2'b11, 1'b1);
    for (int i = 1; i < 6; i++) mstep($sformatf("r032_c%0d", i), 1'b1, 1'b1, 2'b11, 1'b0);
    mstep("r032_chg2", 1'b1, 1'b1, 2'b01, 1'b1);
    chk("r032_restart", glyph(2'b01), BLINK_EN, 2);
    for (int i = 1; i < 4; i++) begin
      mstep($sformatf("r032_on%0d", i), 1'b1, 1'b1, 2'b01, 1'b0);
      chk($sformatf("r032_onx%0d", i), glyph(2'b01), BLINK_EN, 2);
    end
    mstep("r032_off", 1'b1, 1'b1, 2'b01, 1'b0);
    mstep("r033_dis", 1'b1, 1'b0, 2'b01, 1'b1);
    chk("r033_blank", BLANK, 1'b0, 2);
    mstep("r033_reen", 1'b1, 1'b1, 2'b01, 1'b0);
    chk("r033_steady", glyph(2'b01), 1'b0, 2);
    for (int i = 0; i < 3; i++) mstep($sformatf("r033_s%0d", i), 1'b1, 1'b1, 2'b01, 1'b0);

    // Counter saturation with five alternating changes
    mstep("r034_rst", 1'b0, 1'b0, 2'b00, 1'b0);
    mstep("r034_en", 1'b1, 1'b1, 2'b01, 1'b0);
    for (int i = 0; i < 5; i++) begin
      mstep($sformatf("r034_chg%0d", i), 1'b1, 1'b1, (i % 2 == 0) ? 2'b00 : 2'b01, 1'b1);
      mstep($sformatf("r034_gap%0d", i), 1'b1, 1'b1, 2'b10, 1'b0);
    end
    n_chk++;
    if (int'(dir_changes) != 3) begin
      n_err++;
      $display("FAIL r034_sat: got %0d expected 3", dir_changes);
    end

    // Reset in the middle of a blink
    mstep("r035_en", 1'b1, 1'b1, 2'b00, 1'b0);
    mstep("r035_chg", 1'b1, 1'b1, 2'b11, 1'b1);
    for (int i = 0; i < 3; i++) mstep($sformatf("r035_c%0d", i), 1'b1, 1'b1, 2'b11, 1'b0);
    mstep("r035_rst", 1'b0, 1'b1, 2'b10, 1'b1);
    chk("r035_rstval", BLANK, 1'b0, 0);

    for (int i = 0; i < 3000; i++) begin
      mstep($sformatf("rnd%0d", i),
            logic'($urandom_range(0, 63) != 0),
            logic'($urandom_range(0, 15) != 0),
            2'($urandom_range(0, 3)),
            logic'($urandom_range(0, 7) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/dir_display_seq.md
DIR_DISPLAY_SEQ -- requirements
Module: dir_display_seq

Interface
REQ-001 The module SHALL have parameter NUM_DIGITS, default 4, meaning the number of seven-segment digits driven; the legal range is 4..8.
REQ-002 The module SHALL have parameter BLINK_CYCLES, default 25_000_000, meaning the clock cycles per blink half-period; the minimum is 1.
REQ-003 The module SHALL have parameter BLINK_COUNT, default 3, meaning the number of on/off blink pairs after a direction change; the minimum is 1.
REQ-004 The module SHALL have parameter CNT_W, default 8, meaning the width of the direction-change counter.
REQ-005 The module SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The module SHALL have port rst_n, input, 1 bit: synchronous reset, active-low.
REQ-007 The module SHALL have port enable, input, 1 bit: when low, the display is blanked.
REQ-008 The module SHALL have port direc, input, 2 bits: direction code 00 forward, 01 reverse, 10 left, 11 right.
REQ-009 The module SHALL have port dir_valid, input, 1 bit: one-cycle qualifier for direc.
REQ-010 The module SHALL have port hex, output, 7*NUM_DIGITS bits: digit k occupies bits [7k+6:7k], segments active-low, bit6..0 = g..a.
REQ-011 The module SHALL have port busy, output, 1 bit: high while in the BLINK state.
REQ-012 The module SHALL have port dir_changes, output, CNT_W bits: saturating count of accepted direction changes.

Function
REQ-013 All outputs SHALL be registered, updating on the clock edge after the inputs that cause the change are sampled.
REQ-014 The glyphs SHALL be: right 0101111 on digit 0; left 1000111 on digit 1; forward 0001110 on digit 2; reverse 0000011 on digit 3.
REQ-015 All non-selected digits, including digits 4..NUM_DIGITS-1, SHALL always show 1111111.
REQ-016 The FSM SHALL have the states OFF, STEADY and BLINK.
REQ-017 In OFF, all digits SHALL be blank and busy SHALL be 0.
REQ-018 OFF with enable=1 SHALL go to STEADY, latching cur_dir from direc regardless of dir_valid; this does not count as a change.
REQ-019 STEADY SHALL show the cur_dir glyph continuously.
REQ-020 STEADY with dir_valid=1 and direc!=cur_dir SHALL go to BLINK, load cur_dir=direc, clear the blink timer and pair counter, and increment dir_changes.
REQ-021 dir_valid=1 with direc==cur_dir SHALL be ignored in every state.
REQ-022 In BLINK, the glyph SHALL be shown for BLINK_CYCLES, blank for BLINK_CYCLES, repeated BLINK_COUNT times; the state then returns to STEADY, for a total of 2*BLINK_CYCLES*BLINK_COUNT cycles in BLINK.
REQ-023 A new differing direction during BLINK SHALL restart the blink sequence from the on phase with the new glyph, and SHALL increment dir_changes.
REQ-024 enable=0 in any state SHALL go to OFF; it has priority over dir_valid; any blink in progress is abandoned and cur_dir is retained.
REQ-025 dir_changes SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.

Reset
REQ-026 With rst_n=0 at a clock edge, the block SHALL enter: state OFF, cur_dir=00, hex all ones, busy=0, dir_changes=0, timers 0.
REQ-027 Reset SHALL take priority over all other inputs, including mid-BLINK.

Configuration
REQ-028 With macro DIR_DISPLAY_BLINK_EN defined, BLINK behaviour SHALL be as in REQ-020..023.
REQ-029 Without DIR_DISPLAY_BLINK_EN, BLINK and its timers SHALL be absent: a change goes directly to STEADY showing the new glyph one cycle later, busy is tied 0, and dir_changes still counts.

Verification
REQ-030 Reset then enable=1, direc=10 -> hex digit1 = 1000111, all other digits 1111111, dir_changes=0.
REQ-031 With BLINK_CYCLES=4 and BLINK_COUNT=2, in STEADY forward, apply dir_valid pulse with direc=11 -> digit0 on 4 cycles, off 4, on 4, off 4, then steady; busy high for 16 cycles; dir_changes=1.
REQ-032 Mid-blink (cycle 6), apply dir_valid with direc=01 -> digit3 blink restarts from the on phase, digit0 blank, dir_changes=2.
REQ-033 Deassert enable mid-blink -> all digits 1111111 next cycle and busy=0; reassert -> steady glyph with no blink.
REQ-034 With CNT_W=2, apply 5 alternating changes -> dir_changes saturates at 3.
REQ-035 Assert rst_n=0 mid-blink -> the next cycle shows the REQ-026 reset values; build without DIR_DISPLAY_BLINK_EN and repeat REQ-031 -> the glyph changes in 1 cycle and busy stays 0.
